ssn_input_pipe_param: RTL and testbench
=======================================

// Module: ssn_input_pipe_param
//
// PURPOSE
// - Parametrised SSN bus input retiming pipe: generalises the fixed 20-bit, 1-negedge + 1-posedge
//   input pipe to any width, any posedge depth and an optional negedge retiming stage.
// - Adds a reset-release sequencer that holds the datapath cleared for a programmable number of
//   cycles, and a pipe_ready status output.
// - Sits between the SSN bus input pins / upstream node and the SSN receiver/host logic,
//   all on bus_clock.
//
// PARAMETERS
// - DATA_WIDTH  20  SSN bus width, 1..64.
// - PIPE_DEPTH   1  Number of posedge register stages, 1..8.
// - NEG_RETIME   1  1: a negedge retiming stage precedes the posedge stages. 0: no negedge stage.
// - RESET_HOLD   4  Cycles the datapath stays cleared after reset release, 0..15.
//
// PORTS
// - bus_clock     input   1           SSN bus clock; only clock in the block.
// - ijtag_reset   input   1           Reset, asynchronous, active-high.
// - bus_data_in   input   DATA_WIDTH  Incoming SSN bus data.
// - bus_data_out  output  DATA_WIDTH  Retimed SSN bus data.
// - pipe_ready    output  1           1 = sequencer in RUN; output carries live data.
//
// BEHAVIOUR
// Reset and output values
// - ijtag_reset=1 asynchronously forces: state=CLEAR, hold counter=0, pipe_ready=0.
// - bus_data_out is forced to 0 combinationally whenever pipe_ready=0. It therefore reads 0
//   immediately on reset assertion, with no clock edge needed.
// - Data stage registers have no async reset. They clear synchronously, on their own clock edge,
//   while sync_clear=1. sync_clear=1 in CLEAR and HOLD, 0 in RUN.
//
// Sequencer (posedge bus_clock)
// - CLEAR: first posedge with ijtag_reset=0 -> HOLD with cnt=0. If RESET_HOLD=0 -> RUN directly.
// - HOLD: if cnt==RESET_HOLD-1 -> RUN, else cnt<=cnt+1.
// - RUN: stays in RUN until ijtag_reset is asserted. pipe_ready=1, sync_clear=0.
// - pipe_ready rises on posedge number 1+RESET_HOLD after reset release.
// - Reset asserted mid-stream: immediate return to CLEAR. Output drops to 0 asynchronously,
//   in-flight data is discarded, and the full hold sequence repeats after release.
//
// Datapath
// - Optional negedge stage n0, then posedge stages r[0..PIPE_DEPTH-1].
// - bus_data_out = r[PIPE_DEPTH-1] when pipe_ready=1.
// - Latency, NEG_RETIME=1: data sampled on the negedge appears after the next posedge plus
//   PIPE_DEPTH-1 further posedges. That is PIPE_DEPTH posedges measured from a posedge launch.
// - Latency, NEG_RETIME=0: PIPE_DEPTH posedges.
// - No data transformation, no width change, no flow control: every cycle is transferred.
// - After entering RUN, the output shows zeros until the first post-clear sample has reached the
//   last stage. Samples taken while sync_clear=1 are discarded.
// - The negedge stage samples sync_clear on the negedge. This gives a half-cycle release offset
//   vs the posedge stages, which is accepted.
//
// TESTING
// 1. Defaults (20/1/1/4): assert ijtag_reset mid-cycle -> bus_data_out=0 and pipe_ready=0 with
//    no clock edge. Release -> pipe_ready=1 after posedge 5.
// 2. Defaults in RUN, bus_data_in = ramp 0x00001,0x00002,... changing on each posedge ->
//    bus_data_out equals bus_data_in from 1 posedge earlier, with no gaps or duplicates.
// 3. PIPE_DEPTH=4, NEG_RETIME=0, input pattern 0xA5A5A ->
//    the pattern appears at the output exactly 4 posedges after launch.
// 4. Reset pulse of 2 ns during a ramp ->
//    output goes 0 at once, pipe_ready=0, and the re-sequence takes 1+RESET_HOLD posedges.
//    Pre-reset data never reappears at the output.
// 5. RESET_HOLD=0 ->
//    pipe_ready=1 after the first posedge following release. RESET_HOLD=15 -> after posedge 16.
// 6. DATA_WIDTH=1, PIPE_DEPTH=8, walking 0/1 on the input ->
//    output matches with 8-posedge latency. Input toggling during HOLD never reaches the output.

Source files
------------

// File: rtl/ssn_input_pipe_param.sv
// Parametrised SSN bus input retiming pipe with a reset-release sequencer.
// The datapath stays cleared for RESET_HOLD cycles after reset, then carries live data.
module ssn_input_pipe_param #(
    parameter int DATA_WIDTH = 20,
    parameter int PIPE_DEPTH = 1,
    parameter int NEG_RETIME = 1,
    parameter int RESET_HOLD = 4
) (
    input  logic                  bus_clock,
    input  logic                  ijtag_reset,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  pipe_ready
);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [3:0]  HOLD_LAST = 4'(RESET_HOLD - 1);
    localparam int unsigned DEPTH_U   = PIPE_DEPTH;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sync_clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = (RESET_HOLD == 0) ? ST_RUN : ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge bus_clock or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pipe_ready = (state_q == ST_RUN);
    assign sync_clear = ~pipe_ready;

    logic [DATA_WIDTH-1:0] stage_in;

    // The negedge stage sees sync_clear half a cycle after the posedge stages do.
    if (NEG_RETIME != 0) begin : g_neg
        logic [DATA_WIDTH-1:0] n0_q, n0_d;
        always_comb n0_d = sync_clear ? '0 : bus_data_in;
        always_ff @(negedge bus_clock) n0_q <= n0_d;
        assign stage_in = n0_q;
    end else begin : g_noneg
        assign stage_in = bus_data_in;
    end

    logic [DATA_WIDTH-1:0] r_q [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] r_d [PIPE_DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < DEPTH_U; i++) begin
            r_d[i] = '0;
        end
        if (!sync_clear) begin
            r_d[0] = stage_in;
            for (int unsigned i = 1; i < DEPTH_U; i++) begin
                r_d[i] = r_q[i-1];
            end
        end
    end

    always_ff @(posedge bus_clock) begin
        r_q <= r_d;
    end

    // Output masking is combinational so reset blanks the bus without a clock edge.
    assign bus_data_out = pipe_ready ? r_q[PIPE_DEPTH-1] : '0;

endmodule

// File: tb/tb_ssn_input_pipe_param.sv
// Randomised bench for ssn_input_pipe_param across four parameter sets, checked against
// a history-based model: output = input from DEPTH posedges ago if both ends were in RUN.
module tb_ssn_input_pipe_param;

    logic        bus_clock = 1'b0;
    logic        ijtag_reset = 1'b0;
    logic [19:0] din0, din1, din2;
    logic        din3;
    logic [19:0] dout0, dout1, dout2;
    logic        dout3;
    logic        rdy0, rdy1, rdy2, rdy3;

    int total = 0;
    int bad   = 0;
    int p     = 0;
    int phase = 0;

    int          DP [4] = '{1, 4, 2, 8};
    int          HP [4] = '{4, 4, 0, 15};
    logic [19:0] WM [4] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'h00001};
    logic [19:0] hist [4][0:1023];

    always #5 bus_clock = ~bus_clock;

    ssn_input_pipe_param #(.DATA_WIDTH(20), .PIPE_DEPTH(1), .NEG_RETIME(1), .RESET_HOLD(4)) u_dut0 (
        .bus_clock(bus_clock), .ijtag_reset(ijtag_reset), .bus_data_in(din0),
        .bus_data_out(dout0), .pipe_ready(rdy0));
    ssn_input_pipe_param #(.DATA_WIDTH(20), .PIPE_DEPTH(4), .NEG_RETIME(0), .RESET_HOLD(4)) u_dut1 (
        .bus_clock(bus_clock), .ijtag_reset(ijtag_reset), .bus_data_in(din1),
        .bus_data_out(dout1), .pipe_ready(rdy1));
    ssn_input_pipe_param #(.DATA_WIDTH(20), .PIPE_DEPTH(2), .NEG_RETIME(1), .RESET_HOLD(0)) u_dut2 (
        .bus_clock(bus_clock), .ijtag_reset(ijtag_reset), .bus_data_in(din2),
        .bus_data_out(dout2), .pipe_ready(rdy2));
    ssn_input_pipe_param #(.DATA_WIDTH(1), .PIPE_DEPTH(8), .NEG_RETIME(1), .RESET_HOLD(15)) u_dut3 (
        .bus_clock(bus_clock), .ijtag_reset(ijtag_reset), .bus_data_in(din3),
        .bus_data_out(dout3), .pipe_ready(rdy3));

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [19:0] get_out(input int d);
        case (d)
            0:       return dout0;
            1:       return dout1;
            2:       return dout2;
            default: return {19'd0, dout3};
        endcase
    endfunction

    function automatic logic get_rdy(input int d);
        case (d)
            0:       return rdy0;
            1:       return rdy1;
            2:       return rdy2;
            default: return rdy3;
        endcase
    endfunction

    function automatic logic [19:0] gen(input int d, input int k);
        logic [19:0] v;
        v = 20'($urandom);
        if (phase == 1) begin
            case (d)
                0: v = 20'(k + 1);
                1: v = (k % 5 == 0) ? 20'hA5A5A : 20'h00000;
                3: v = 20'(k % 2);
                default: ;
            endcase
        end
        return v & WM[d];
    endfunction

    task automatic drive();
        for (int d = 0; d < 4; d++) begin
            hist[d][p] = gen(d, p);
        end
        din0 = hist[0][p];
        din1 = hist[1][p];
        din2 = hist[2][p];
        din3 = hist[3][p][0];
    endtask

    task automatic check_all();
        logic        er;
        logic [19:0] eo;
        for (int d = 0; d < 4; d++) begin
            er = (p >= 1 + HP[d]);
            eo = (er && (p - DP[d] >= 1 + HP[d])) ? hist[d][p - DP[d]] : 20'd0;
            check($sformatf("d%0d_ready", d), {19'd0, get_rdy(d)}, {19'd0, er});
            check($sformatf("d%0d_out", d), get_out(d), eo);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s_d%0d_ready", tag, d), {19'd0, get_rdy(d)}, 20'd0);
            check($sformatf("%s_d%0d_out", tag, d), get_out(d), 20'd0);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge bus_clock);
            #1;
            p++;
            check_all();
            drive();
        end
    endtask

    task automatic release_reset();
        ijtag_reset = 1'b0;
        p = 0;
        drive();
    endtask

    // Short pulse placed mid-cycle, well away from both clock edges.
    task automatic reset_pulse(input string tag);
        #1 ijtag_reset = 1'b1;
        #1 check_reset_state(tag);
        #1 release_reset();
    endtask

    initial begin
        p = 0;
        drive();
        #1 ijtag_reset = 1'b1;
        #1 check_reset_state("por");
        for (int i = 0; i < 3; i++) begin
            @(posedge bus_clock);
            #1 check_reset_state("por_clk");
        end
        #1 release_reset();

        phase = 0;
        step(40);
        reset_pulse("pulse1");
        phase = 1;
        step(50);
        reset_pulse("pulse2");
        step(3);
        reset_pulse("pulse_in_hold");
        phase = 0;
        step(40);
        phase = 1;
        step(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
